// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, write port, reserve port and ready.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned N_READ = 2
);
  logic [N_READ*ADDR_W-1:0] rd_addr_i;
  logic [N_READ*DATA_W-1:0] rd_data_o;
  logic [N_READ-1:0]        rd_busy_o;
  logic                     we_i;
  logic [ADDR_W-1:0]        wr_addr_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic                     rsv_i;
  logic [ADDR_W-1:0]        rsv_addr_i;
  logic                     ready_o;

  modport master (
    output rd_addr_i, we_i, wr_addr_i, wr_data_i, rsv_i, rsv_addr_i,
    input  rd_data_o, rd_busy_o, ready_o
  );

  modport slave (
    input  rd_addr_i, we_i, wr_addr_i, wr_data_i, rsv_i, rsv_addr_i,
    output rd_data_o, rd_busy_o, ready_o
  );
endinterface

// File: rtl/regfile_sb.sv
// N-read / 1-write register file with pending-write scoreboard and post-reset clearing sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read lanes.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned N_READ = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  regfile_sb_if.slave  bus
);

  localparam int unsigned NREG = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_idx_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem_q [NREG];
  logic [NREG-1:0]     pend_q;

  logic [N_READ*DATA_W-1:0] rd_data_c;
  logic [N_READ-1:0]        rd_busy_c;
  logic [ADDR_W-1:0]        rd_a;

  // Sweep on reset; in RUN a same-cycle reserve overrides the write's pending clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          mem_q[clr_idx_q]  <= '0;
          pend_q[clr_idx_q] <= 1'b0;
          clr_idx_q         <= clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == ADDR_W'(NREG - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.we_i && bus.wr_addr_i != '0) begin
            mem_q[bus.wr_addr_i]  <= bus.wr_data_i;
            pend_q[bus.wr_addr_i] <= 1'b0;
          end
          if (bus.rsv_i && bus.rsv_addr_i != '0) begin
            pend_q[bus.rsv_addr_i] <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Combinational read lanes; x0 and the whole INIT phase read as zero / not busy.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    rd_a      = '0;
    for (int k = 0; k < int'(N_READ); k++) begin
      rd_a = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
      if (state_q == RUN && rd_a != '0) begin
        rd_data_c[k*DATA_W +: DATA_W] = mem_q[rd_a];
        rd_busy_c[k]                  = pend_q[rd_a];
`ifdef REGFILE_BYPASS_EN
        if (bus.we_i && bus.wr_addr_i == rd_a) begin
          rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data_i;
          rd_busy_c[k]                  = bus.rsv_i && (bus.rsv_addr_i == rd_a);
        end
`endif
      end
    end
  end

  assign bus.rd_data_o = rd_data_c;
  assign bus.rd_busy_o = rd_busy_c;
  assign bus.ready_o   = ready_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an N-read / 1-write port set, a per-register pending-write scoreboard, and a post-reset clearing sweep. It replaces the fixed 32x32 two-read-port register file in the pipeline's decode stage. The scoreboard lets decode stall on in-flight producers, and `ready_o` gates instruction issue until every register is zeroed.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register address width; the file holds `2**ADDR_W` registers, and register 0 is hard-wired to zero
- `N_READ`, 2, number of read ports (1..4)

Ports:
- `clk_i` input 1: clock; all state updates on its rising edge
- `rst_i` input 1: reset, synchronous and active-high
- `rd_addr_i` input `N_READ*ADDR_W`: read addresses, packed; port k occupies bits `[k*ADDR_W +: ADDR_W]`
- `rd_data_o` output `N_READ*DATA_W`: read data, packed the same way
- `rd_busy_o` output `N_READ`: bit k is 1 when port k's register has a pending write
- `we_i` input 1: write enable
- `wr_addr_i` input `ADDR_W`: write address
- `wr_data_i` input `DATA_W`: write data
- `rsv_i` input 1: reserve request; marks `rsv_addr_i` pending
- `rsv_addr_i` input `ADDR_W`: destination register being reserved
- `ready_o` output 1: high once the clearing sweep is done

## Operation
- State machine has two states:
  - `INIT` (entered on reset).
  - `RUN`.
- `INIT` behaviour:
  - A counter `clr_idx` (ADDR_W bits) starts at 0.
  - Each cycle, `register[clr_idx]` is written with 0 and `pending[clr_idx]` is cleared, then `clr_idx` increments.
  - When `clr_idx == 2**ADDR_W-1` is cleared, the next state is `RUN`.
  - `we_i` and `rsv_i` are ignored in `INIT`.
  - All `rd_data_o` lanes read 0 and all `rd_busy_o` bits read 0.
- Reads in `RUN` are combinational.
  - Address 0 returns 0 with busy 0.
  - Any other address returns the stored value and its `pending` bit.
- Write in `RUN`:
  - When `we_i` is high and `wr_addr_i != 0`, the register is updated and its `pending` bit is cleared at the edge.
  - A write to address 0 is discarded.
- Reserve in `RUN`: when `rsv_i` is high and `rsv_addr_i != 0`, the `pending` bit is set at the edge. Reserving address 0 has no effect.
- Same-cycle write and reserve to the same nonzero address: the data is written and `pending` ends at 1, because the reserve belongs to a newer producer.
- Write to a register that is not pending: the data is written and `pending` stays 0. This is legal.
- Multiple read ports may use the same address and each returns identical data.

## Timing
- Reset values:
  - `ready_o` = 0.
  - All `rd_busy_o` bits = 0.
  - All `rd_data_o` lanes = 0.
  - State `INIT`, `clr_idx` = 0.
  - All `pending` bits are 0 by the end of the sweep.
- The sweep lasts exactly `2**ADDR_W` cycles after the cycle in which `rst_i` is low. `ready_o` rises on the edge that ends the last clear: 32 cycles for the defaults.
- `rst_i` asserted at any time, including mid-sweep, returns the block to `INIT` with `clr_idx = 0` on the next edge and restarts the sweep in full.
- Read data latency is 0 cycles (combinational from `rd_addr_i`). Written data is visible on the cycle after the write edge.
- A reserve is visible on `rd_busy_o` the cycle after the edge.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding is enabled.
  - In `RUN`, when `we_i` is high and `wr_addr_i` equals a nonzero read address, that lane returns `wr_data_i` in the same cycle.
  - That lane's `rd_busy_o` reads 0, unless a same-cycle `rsv_i` targets the same address, in which case busy reads 1.
- Undefined: no forwarding. A same-cycle read returns the old value and the old `pending` bit; the new value appears next cycle.

## Test plan
- Sweep: assert `rst_i` for 1 cycle, then release.
  - `ready_o` is 0 for 32 cycles and 1 from cycle 32.
  - During the sweep, a write of 0xDEADBEEF to x5 is ignored, so x5 reads 0 after the sweep.
- Basic write and x0 protection:
  - Write 0x12345678 to x7, then read x7 on port 0 and port 1: both return 0x12345678.
  - Write 0xFFFFFFFF to x0: x0 reads 0.
- Scoreboard:
  - Reserve x3: `rd_busy_o` for x3 is 1 next cycle.
  - Write 0xA5A5A5A5 to x3: busy is 0 next cycle and data reads 0xA5A5A5A5.
  - Write and reserve x3 in the same cycle: busy stays 1.
- Bypass (`REGFILE_BYPASS_EN`), with x9 = 1:
  - Write 0x55 to x9 while reading x9: `rd_data_o` is 0x55 in the same cycle.
  - Without the macro, the same-cycle read returns 1.
- Mid-sweep reset: assert `rst_i` at sweep cycle 10.
  - `ready_o` stays 0 for 32 further cycles.
  - A register written before the first reset reads 0 afterwards.
